// File: rtl/bus_dma_arbiter.sv
// Bus ownership arbiter for the CPU and two NPR DMA channels. It has a registered grant FSM and steers the owner's request onto the bus.
// Define ARB_BURST_LIMIT_EN to preempt a DMA owner after BURST_MAX cycles when another master is waiting.
module bus_dma_arbiter #(
  parameter int AW        = 22,
  parameter int DW        = 16,
  parameter int BURST_MAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dma_enable,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic          cpu_byte_op,
  input  logic [DW-1:0] cpu_data,
  output logic          cpu_gnt,
  input  logic          dma0_req,
  input  logic [AW-1:0] dma0_addr,
  input  logic          dma0_rd,
  input  logic          dma0_wr,
  input  logic          dma0_byte_op,
  input  logic [DW-1:0] dma0_data,
  output logic          dma0_gnt,
  input  logic          dma1_req,
  input  logic [AW-1:0] dma1_addr,
  input  logic          dma1_rd,
  input  logic          dma1_wr,
  input  logic          dma1_byte_op,
  input  logic [DW-1:0] dma1_data,
  output logic          dma1_gnt,
  output logic [AW-1:0] bus_addr,
  output logic          bus_rd,
  output logic          bus_wr,
  output logic          bus_byte_op,
  output logic [DW-1:0] bus_data_in,
  output logic [1:0]    grant_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CPU  = 2'b01,
    ST_DMA0 = 2'b10,
    ST_DMA1 = 2'b11
  } state_t;

  state_t state_r, state_next_s;
  logic   rr_r;  // 0: DMA0 wins a tie, 1: DMA1 wins a tie
  logic   dma0_eff_s, dma1_eff_s;
  logic   dma0_cand_s, dma1_cand_s;
  logic   dma0_preempt_s, dma1_preempt_s;

  assign dma0_eff_s = dma0_req & dma_enable;
  assign dma1_eff_s = dma1_req & dma_enable;

`ifdef ARB_BURST_LIMIT_EN
  localparam int            CW         = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_MAX - 1);
  localparam logic [CW-1:0] BURST_TOP  = CW'(BURST_MAX);

  logic [CW-1:0] burst_cnt_r;
  logic [1:0]    excl_r;  // channel preempted last; barred from the next decision
  logic          burst_hit_s;

  // The current cycle counts as an owned cycle, so compare against BURST_MAX-1.
  assign burst_hit_s    = (burst_cnt_r >= BURST_LAST);
  assign dma0_preempt_s = burst_hit_s & (dma1_eff_s | cpu_req) & ~dma0_rd & ~dma0_wr;
  assign dma1_preempt_s = burst_hit_s & (dma0_eff_s | cpu_req) & ~dma1_rd & ~dma1_wr;
  assign dma0_cand_s    = dma0_eff_s & ~excl_r[0];
  assign dma1_cand_s    = dma1_eff_s & ~excl_r[1];

  // Burst counter and one-shot exclusion of a preempted channel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_cnt_r <= {CW{1'b0}};
      excl_r      <= 2'b00;
    end else begin
      if (state_next_s == ST_IDLE) begin
        burst_cnt_r <= {CW{1'b0}};
      end else if ((state_r == ST_DMA0 || state_r == ST_DMA1) && burst_cnt_r != BURST_TOP) begin
        burst_cnt_r <= burst_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        burst_cnt_r <= burst_cnt_r;
      end
      if (state_r == ST_DMA0 && dma0_preempt_s) begin
        excl_r <= 2'b01;
      end else if (state_r == ST_DMA1 && dma1_preempt_s) begin
        excl_r <= 2'b10;
      end else if (state_r == ST_IDLE) begin
        excl_r <= 2'b00;
      end else begin
        excl_r <= excl_r;
      end
    end
  end
`else
  localparam int burst_max_unused = BURST_MAX;

  assign dma0_preempt_s = 1'b0;
  assign dma1_preempt_s = 1'b0;
  assign dma0_cand_s    = dma0_eff_s;
  assign dma1_cand_s    = dma1_eff_s;
`endif

  // Next-state selection: DMA over CPU, and an owner is never dropped mid-strobe
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (dma0_cand_s & dma1_cand_s) begin
          state_next_s = rr_r ? ST_DMA1 : ST_DMA0;
        end else if (dma0_cand_s) begin
          state_next_s = ST_DMA0;
        end else if (dma1_cand_s) begin
          state_next_s = ST_DMA1;
        end else if (cpu_req) begin
          state_next_s = ST_CPU;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CPU: begin
        if (~cpu_req & ~cpu_rd & ~cpu_wr) state_next_s = ST_IDLE;
        else                              state_next_s = ST_CPU;
      end
      ST_DMA0: begin
        if ((~dma0_eff_s & ~dma0_rd & ~dma0_wr) | dma0_preempt_s) state_next_s = ST_IDLE;
        else                                                      state_next_s = ST_DMA0;
      end
      ST_DMA1: begin
        if ((~dma1_eff_s & ~dma1_rd & ~dma1_wr) | dma1_preempt_s) state_next_s = ST_IDLE;
        else                                                      state_next_s = ST_DMA1;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Grant state register and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      rr_r    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (state_r == ST_DMA0 && state_next_s != ST_DMA0) begin
        rr_r <= 1'b1;
      end else if (state_r == ST_DMA1 && state_next_s != ST_DMA1) begin
        rr_r <= 1'b0;
      end else begin
        rr_r <= rr_r;
      end
    end
  end

  // Steer only the current owner's request onto the bus
  always_comb begin
    bus_addr    = {AW{1'b0}};
    bus_rd      = 1'b0;
    bus_wr      = 1'b0;
    bus_byte_op = 1'b0;
    bus_data_in = {DW{1'b0}};
    case (state_r)
      ST_CPU: begin
        bus_addr    = cpu_addr;
        bus_rd      = cpu_rd;
        bus_wr      = cpu_wr;
        bus_byte_op = cpu_byte_op;
        bus_data_in = cpu_data;
      end
      ST_DMA0: begin
        bus_addr    = dma0_addr;
        bus_rd      = dma0_rd;
        bus_wr      = dma0_wr;
        bus_byte_op = dma0_byte_op;
        bus_data_in = dma0_data;
      end
      ST_DMA1: begin
        bus_addr    = dma1_addr;
        bus_rd      = dma1_rd;
        bus_wr      = dma1_wr;
        bus_byte_op = dma1_byte_op;
        bus_data_in = dma1_data;
      end
      default: begin
        bus_addr    = {AW{1'b0}};
        bus_rd      = 1'b0;
        bus_wr      = 1'b0;
        bus_byte_op = 1'b0;
        bus_data_in = {DW{1'b0}};
      end
    endcase
  end

  assign cpu_gnt     = (state_r == ST_CPU);
  assign dma0_gnt    = (state_r == ST_DMA0);
  assign dma1_gnt    = (state_r == ST_DMA1);
  assign grant_state = state_r;

endmodule

// File: tb/tb_bus_dma_arbiter.sv
// Directed, scoreboard-driven bench for bus_dma_arbiter.
// Expectations are queued when stimulus is driven and compared after the following clock edge.
module tb_bus_dma_arbiter;
  localparam int AW = 22;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          dma_enable;
  logic          cpu_req, cpu_rd, cpu_wr, cpu_byte_op, cpu_gnt;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data;
  logic          dma0_req, dma0_rd, dma0_wr, dma0_byte_op, dma0_gnt;
  logic [AW-1:0] dma0_addr;
  logic [DW-1:0] dma0_data;
  logic          dma1_req, dma1_rd, dma1_wr, dma1_byte_op, dma1_gnt;
  logic [AW-1:0] dma1_addr;
  logic [DW-1:0] dma1_data;
  logic [AW-1:0] bus_addr;
  logic          bus_rd, bus_wr, bus_byte_op;
  logic [DW-1:0] bus_data_in;
  logic [1:0]    grant_state;

  always #5 clk = ~clk;

  bus_dma_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(16)) dut (
    .clk(clk), .reset(reset), .dma_enable(dma_enable),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_byte_op(cpu_byte_op), .cpu_data(cpu_data), .cpu_gnt(cpu_gnt),
    .dma0_req(dma0_req), .dma0_addr(dma0_addr), .dma0_rd(dma0_rd), .dma0_wr(dma0_wr),
    .dma0_byte_op(dma0_byte_op), .dma0_data(dma0_data), .dma0_gnt(dma0_gnt),
    .dma1_req(dma1_req), .dma1_addr(dma1_addr), .dma1_rd(dma1_rd), .dma1_wr(dma1_wr),
    .dma1_byte_op(dma1_byte_op), .dma1_data(dma1_data), .dma1_gnt(dma1_gnt),
    .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_byte_op(bus_byte_op),
    .bus_data_in(bus_data_in), .grant_state(grant_state)
  );

  typedef struct {
    string         tag;
    logic [1:0]    gs;
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic          bop;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [1:0] GS_IDLE = 2'b00;
  localparam logic [1:0] GS_CPU  = 2'b01;
  localparam logic [1:0] GS_DMA0 = 2'b10;
  localparam logic [1:0] GS_DMA1 = 2'b11;

  function automatic logic [2:0] gnt_of(input logic [1:0] gs);
    case (gs)
      GS_CPU:  return 3'b001;
      GS_DMA0: return 3'b010;
      GS_DMA1: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic push(input string tag, input logic [1:0] gs, input logic [AW-1:0] a,
                      input logic r, input logic w, input logic b, input logic [DW-1:0] d);
    exp_t e;
    e.tag = tag; e.gs = gs; e.addr = a; e.rd = r; e.wr = w; e.bop = b; e.data = d;
    sb.push_back(e);
  endtask

  task automatic push_idle(input string tag);
    push(tag, GS_IDLE, 22'h000000, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic cmp(input string tag, input string field, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
    end
  endtask

  task automatic check();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      cmp(e.tag, "grant_state", {30'h0, grant_state}, {30'h0, e.gs});
      cmp(e.tag, "gnt", {29'h0, dma1_gnt, dma0_gnt, cpu_gnt}, {29'h0, gnt_of(e.gs)});
      cmp(e.tag, "bus_addr", {10'h0, bus_addr}, {10'h0, e.addr});
      cmp(e.tag, "bus_rd", {31'h0, bus_rd}, {31'h0, e.rd});
      cmp(e.tag, "bus_wr", {31'h0, bus_wr}, {31'h0, e.wr});
      cmp(e.tag, "bus_byte_op", {31'h0, bus_byte_op}, {31'h0, e.bop});
      cmp(e.tag, "bus_data_in", {16'h0, bus_data_in}, {16'h0, e.data});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    tick();
    check();
  endtask

  task automatic cpu(input logic req, input logic [AW-1:0] a, input logic r, input logic w,
                     input logic b, input logic [DW-1:0] d);
    cpu_req = req; cpu_addr = a; cpu_rd = r; cpu_wr = w; cpu_byte_op = b; cpu_data = d;
  endtask

  task automatic dma0(input logic req, input logic [AW-1:0] a, input logic r, input logic w,
                      input logic b, input logic [DW-1:0] d);
    dma0_req = req; dma0_addr = a; dma0_rd = r; dma0_wr = w; dma0_byte_op = b; dma0_data = d;
  endtask

  task automatic dma1(input logic req, input logic [AW-1:0] a, input logic r, input logic w,
                      input logic b, input logic [DW-1:0] d);
    dma1_req = req; dma1_addr = a; dma1_rd = r; dma1_wr = w; dma1_byte_op = b; dma1_data = d;
  endtask

  initial begin
    reset      = 1'b0;
    dma_enable = 1'b1;
    cpu(1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 16'h0000);
    dma0(1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 16'h0000);
    dma1(1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 16'h0000);

    // Reset state, visible before any clock edge
    #3;
    push_idle("reset_initial");
    check();
    tick();
    tick();
    reset = 1'b1;
    push_idle("idle_no_req");
    step();

    // CPU only: grant one cycle later, steered write, release to IDLE
    cpu(1'b1, 22'h000004, 1'b0, 1'b1, 1'b0, 16'h1234);
    push("cpu_grant", GS_CPU, 22'h000004, 1'b0, 1'b1, 1'b0, 16'h1234);
    step();
    push("cpu_hold", GS_CPU, 22'h000004, 1'b0, 1'b1, 1'b0, 16'h1234);
    step();
    cpu(1'b0, 22'h000004, 1'b0, 1'b0, 1'b0, 16'h1234);
    push_idle("cpu_release");
    step();

    // DMA has priority over the CPU; CPU strobes stay off the bus meanwhile
    cpu(1'b1, 22'h000008, 1'b1, 1'b0, 1'b0, 16'h0000);
    dma0(1'b1, 22'h000100, 1'b0, 1'b1, 1'b0, 16'hABCD);
    push("prio_dma0", GS_DMA0, 22'h000100, 1'b0, 1'b1, 1'b0, 16'hABCD);
    step();
    dma0(1'b0, 22'h000100, 1'b0, 1'b0, 1'b0, 16'hABCD);
    push_idle("prio_gap");
    step();
    push("prio_cpu", GS_CPU, 22'h000008, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    cpu(1'b0, 22'h000008, 1'b0, 1'b0, 1'b0, 16'h0000);
    push_idle("prio_cpu_release");
    step();

    // Asynchronous reset in the middle of a DMA0 write
    dma0(1'b1, 22'h000200, 1'b0, 1'b1, 1'b0, 16'h5555);
    push("pre_reset_dma0", GS_DMA0, 22'h000200, 1'b0, 1'b1, 1'b0, 16'h5555);
    step();
    #2;
    reset = 1'b0;
    #1;
    push_idle("reset_mid_grant");
    check();
    dma0(1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    reset = 1'b1;
    push_idle("post_reset_idle");
    step();

    // Round-robin between two DMA channels that keep requesting
    dma0(1'b1, 22'h001000, 1'b0, 1'b0, 1'b0, 16'h0A0A);
    dma1(1'b1, 22'h002000, 1'b0, 1'b0, 1'b1, 16'hB0B0);
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 4; k++) begin
        if (g % 2 == 0) push("rr_dma0", GS_DMA0, 22'h001000, 1'b0, 1'b0, 1'b0, 16'h0A0A);
        else            push("rr_dma1", GS_DMA1, 22'h002000, 1'b0, 1'b0, 1'b1, 16'hB0B0);
        step();
      end
      if (g % 2 == 0) dma0_req = 1'b0;
      else            dma1_req = 1'b0;
      push_idle("rr_gap");
      step();
      dma0_req = 1'b1;
      dma1_req = 1'b1;
    end
    dma0_req = 1'b0;
    dma1_req = 1'b0;
    push_idle("rr_done");
    step();

    // DMA requests ignored while dma_enable is low
    dma_enable = 1'b0;
    dma0(1'b1, 22'h000300, 1'b0, 1'b0, 1'b0, 16'h0000);
    cpu(1'b1, 22'h000010, 1'b0, 1'b0, 1'b0, 16'h0000);
    push("dis_cpu", GS_CPU, 22'h000010, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    push("dis_cpu_hold", GS_CPU, 22'h000010, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    cpu(1'b0, 22'h000010, 1'b0, 1'b0, 1'b0, 16'h0000);
    dma0(1'b0, 22'h000300, 1'b0, 1'b0, 1'b0, 16'h0000);
    push_idle("dis_release");
    step();

    // dma_enable drops during a DMA1 read: held until the read strobe clears
    dma_enable = 1'b1;
    dma1(1'b1, 22'h3FF000, 1'b1, 1'b0, 1'b1, 16'h0000);
    push("dma1_read", GS_DMA1, 22'h3FF000, 1'b1, 1'b0, 1'b1, 16'h0000);
    step();
    dma_enable = 1'b0;
    push("dma1_held_a", GS_DMA1, 22'h3FF000, 1'b1, 1'b0, 1'b1, 16'h0000);
    step();
    push("dma1_held_b", GS_DMA1, 22'h3FF000, 1'b1, 1'b0, 1'b1, 16'h0000);
    step();
    dma1_rd = 1'b0;
    push_idle("dma1_revoked");
    step();
    push_idle("dma1_not_regranted");
    step();
    dma_enable = 1'b1;
    push("dma1_reenabled", GS_DMA1, 22'h3FF000, 1'b0, 1'b0, 1'b1, 16'h0000);
    step();
    dma1(1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 16'h0000);
    push_idle("dma1_release");
    step();

    // Long DMA0 burst with the CPU waiting from the third owner cycle
    dma0(1'b1, 22'h000400, 1'b0, 1'b0, 1'b0, 16'h0000);
    push("burst_dma0", GS_DMA0, 22'h000400, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    for (int i = 2; i <= 16; i++) begin
      if (i == 3) cpu(1'b1, 22'h000020, 1'b0, 1'b0, 1'b0, 16'h0000);
      push("burst_dma0", GS_DMA0, 22'h000400, 1'b0, 1'b0, 1'b0, 16'h0000);
      step();
    end
`ifdef ARB_BURST_LIMIT_EN
    push_idle("burst_preempt");
    step();
    push("burst_cpu", GS_CPU, 22'h000020, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
`else
    for (int i = 17; i <= 24; i++) begin
      push("burst_hold", GS_DMA0, 22'h000400, 1'b0, 1'b0, 1'b0, 16'h0000);
      step();
    end
`endif
    cpu(1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 16'h0000);
    dma0(1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 16'h0000);
    push_idle("burst_done");
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
